// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - round-robin arbiter sharing one APB master port among NUM_REQ requesters
module apb_rr_master #(
    parameter int APB_DW  = 32,
    parameter int APB_AW  = 32,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*APB_AW-1:0] req_addr,
    input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [APB_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [APB_AW-1:0]         paddr,
    output logic [APB_DW-1:0]         pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [APB_DW-1:0]         prdata,
    input  logic                      pready
);

    localparam int PW = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       gnt_q;
    logic [CW-1:0]       cnt_q;
    logic [APB_AW-1:0]   paddr_q;
    logic [APB_DW-1:0]   pwdata_q;
    logic                pwrite_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [APB_DW-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic                found;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       cand;
    logic                accept;
    logic                timeout_hit;
    logic                done;

    // Search starts just after the last granted requester and wraps around.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign accept      = (state_q == S_IDLE) && found;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1)) && !pready;
    assign done        = (state_q == S_ACCESS) && (pready || timeout_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
        penable   = (state_q == S_ACCESS);
        req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= PW'(NUM_REQ - 1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (accept) begin
                gnt_q    <= win_idx;
                paddr_q  <= req_addr[win_idx*APB_AW +: APB_AW];
                pwdata_q <= req_wdata[win_idx*APB_DW +: APB_DW];
                pwrite_q <= req_write[win_idx];
            end
            // Wait counter restarts for every transfer and sticks at its maximum.
            if (state_q == S_SETUP) begin
                cnt_q <= '0;
            end else if (state_q == S_ACCESS && !pready && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done) begin
                rsp_valid_q <= NUM_REQ'(1) << gnt_q;
                rsp_err_q   <= !pready;
                rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
                ptr_q       <= gnt_q;
            end
        end
    end

    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master with a transaction-level model
module tb_apb_rr_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic [AW-1:0]   paddr;
    logic            rsp_err, pwrite, psel, penable, pready;

    logic            vld [N];
    logic            wr  [N];
    logic [AW-1:0]   adr [N];
    logic [DW-1:0]   wdt [N];

    int              checks = 0;
    int              errors = 0;
    int              mptr;
    logic [DW-1:0]   last_rd;
    logic            last_err;
    int              cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = vld[i];
            req_write[i]           = wr[i];
            req_addr[i*AW +: AW]   = adr[i];
            req_wdata[i*DW +: DW]  = wdt[i];
        end
    end

    apb_rr_master #(.APB_DW(DW), .APB_AW(AW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_winner();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (mptr + k) % N;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    // Entered in an IDLE cycle with requests settled; returns in the response cycle.
    task automatic xfer(input int waits, input bit tmo, input bit drop,
                        input logic [DW-1:0] rdv, input bit rnd);
        int            g;
        int            n;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] rd;
        logic          ew;
        g = model_winner();
        if (g < 0) return;
        chk("idle_ready", req_ready, 32'(1 << g));
        ea = adr[g];
        ed = wdt[g];
        ew = wr[g];
        step();
        if (drop) vld[g] = 1'b0;
        pready = 1'b0;
        #1;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, ea);
        chk("setup_pwdata", pwdata, ed);
        chk("setup_pwrite", pwrite, ew);
        chk("setup_ready", req_ready, 0);
        chk("setup_rsp_valid", rsp_valid, 0);
        chk("hold_rdata", rsp_rdata, last_rd);
        chk("hold_err", rsp_err, last_err);
        n  = tmo ? TO : waits + 1;
        rd = '0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("acc_psel", psel, 1);
            chk("acc_penable", penable, 1);
            chk("acc_paddr", paddr, ea);
            chk("acc_ready", req_ready, 0);
            pready = !tmo && (i == waits);
            if (pready) begin
                rd     = rnd ? DW'($urandom) : rdv;
                prdata = rd;
            end else begin
                prdata = DW'($urandom);
            end
        end
        step();
        pready = 1'b0;
        #1;
        last_rd  = (tmo || ew) ? '0 : rd;
        last_err = tmo;
        mptr     = g;
        chk("rsp_valid", rsp_valid, 32'(1 << g));
        chk("rsp_err", rsp_err, last_err);
        chk("rsp_rdata", rsp_rdata, last_rd);
        chk("rsp_psel", psel, 0);
        chk("rsp_penable", penable, 0);
    endtask

    task automatic load(input int i);
        vld[i] = 1'b1;
        wr[i]  = 1'($urandom);
        adr[i] = AW'($urandom);
        wdt[i] = DW'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; wr[i] = 1'b0; adr[i] = '0; wdt[i] = '0;
        end
        pready   = 1'b0;
        prdata   = '0;
        reset_n  = 1'b0;
        mptr     = N - 1;
        last_rd  = '0;
        last_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        reset_n = 1'b1;
        step();

        // zero-wait write from req0
        vld[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h10; wdt[0] = 32'hA5A50001;
        #1;
        xfer(0, 0, 1, '0, 1);

        // req1 arrives in req0's response cycle
        load(1);
        #1;
        chk("resp_cycle_ready", req_ready, 4'b0010);
        xfer($urandom_range(0, 2), 0, 1, '0, 1);

        // read from req2 with three wait states
        vld[2] = 1'b1; wr[2] = 1'b0; adr[2] = AW'($urandom); wdt[2] = DW'($urandom);
        #1;
        xfer(3, 0, 1, 32'hDEADBEEF, 0);
        chk("read_deadbeef", rsp_rdata, 32'hDEADBEEF);

        // pready stuck low on req3
        load(3);
        #1;
        xfer(0, 1, 1, '0, 1);

        // all requesters held high
        for (int i = 0; i < N; i++) load(i);
        #1;
        t_prev = cyc;
        for (int j = 0; j < 5; j++) begin
            chk("rr_order", req_ready, 32'(1 << (j % N)));
            if (j > 0) chk("b2b_period", 32'(cyc - t_prev), 3);
            t_prev = cyc;
            xfer(0, 0, 0, '0, 1);
        end
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        #1;
        chk("cleared_ready", req_ready, 0);

        // reset in the middle of ACCESS
        load(3);
        #1;
        chk("pre_rst_ready", req_ready, 4'b1000);
        step();
        vld[3] = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_paddr", paddr, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        step();
        step();
        reset_n  = 1'b1;
        mptr     = N - 1;
        last_rd  = '0;
        last_err = 1'b0;
        pready   = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_psel", psel, 0);
        end
        pready = 1'b0;
        for (int i = 0; i < N; i++) load(i);
        #1;
        chk("post_rst_first", req_ready, 4'b0001);
        xfer(1, 0, 1, '0, 1);
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        #1;

        // randomized traffic; pending requesters keep their payload
        for (int it = 0; it < 24; it++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) load(i);
                if (vld[i]) any = 1'b1;
            end
            if (!any) load($urandom_range(0, N - 1));
            #1;
            xfer($urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1, '0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
